// File: rtl/al_clksw_pkg.sv
// Shared types and helpers for the N-channel clock-switch sequencer.
package al_clksw_pkg;

   // Widest channel vector the helpers support
   localparam int unsigned MAX_CH = 16;

   typedef enum logic [2:0] {
      StIdle,
      StDrain,
      StSwitch,
      StArm,
      StEnable,
      StRevert
   } clksw_state_e;

   // One-hot of idx within an n-channel vector; all-zero when idx is out of range
   function automatic logic [MAX_CH-1:0] onehot(input int unsigned idx, input int unsigned n);
      return (idx < n) ? (MAX_CH'(1) << idx) : '0;
   endfunction

   // Ceiling log2 for sizing counters at elaboration time
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/al_logic_clksw_ctrl_if.sv
// Request/acknowledge and switch-primitive signals of the clock-switch sequencer.
interface al_logic_clksw_ctrl_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned SEL_W  = 2
);
   logic              req_valid;
   logic [SEL_W-1:0]  req_sel;
   logic              req_ready;
   logic [NUM_CH-1:0] ch_alive;
   logic [NUM_CH-1:0] ce;
   logic [NUM_CH-1:0] sel;
   logic [SEL_W-1:0]  cur_sel;
   logic              done;
   logic              err;

   modport master (
      output req_valid, req_sel, ch_alive,
      input  req_ready, ce, sel, cur_sel, done, err
   );

   modport slave (
      input  req_valid, req_sel, ch_alive,
      output req_ready, ce, sel, cur_sel, done, err
   );
endinterface

// File: rtl/al_clksw_cnt.sv
// Loadable down-counter that saturates at zero and flags terminal count.
module al_clksw_cnt #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             tc
);
   logic [WIDTH-1:0] count_q, count_d;

   // Load wins over decrement; decrement stops at zero
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign tc = (count_q == '0);
endmodule

// File: rtl/al_logic_clksw_ctrl.sv
// Break-before-make clock-switch sequencer driving per-channel ce and one-hot sel.
module al_logic_clksw_ctrl
   import al_clksw_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned SEL_W       = 2,
   parameter int unsigned INIT_SEL    = 0,
   parameter int unsigned HOLD_CYC    = 4,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input logic                  clk,
   input logic                  rst,
   al_logic_clksw_ctrl_if.slave bus
);
   localparam int unsigned CNT_MAX = (TIMEOUT_CYC > HOLD_CYC) ? TIMEOUT_CYC : HOLD_CYC;
   localparam int unsigned CNT_W   = clog2(CNT_MAX + 1);
   // DRAIN spans HOLD_CYC cycles; ARM and REVERT idle HOLD_CYC cycles and act on the next one
   localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC);
   localparam logic [CNT_W-1:0] TOUT_LD  = CNT_W'(TIMEOUT_CYC - 1);

   clksw_state_e      state_q, state_d;
   logic [SEL_W-1:0]  target_q, target_d;
   logic [SEL_W-1:0]  prev_q, prev_d;
   logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              hold_load, hold_dec, hold_tc;
   logic [CNT_W-1:0]  hold_val;
   logic              tout_load, tout_dec, tout_tc;
   logic              req_ok;
   logic [NUM_CH-1:0] cur_oh;
   logic [NUM_CH-1:0] ce_c;

   assign req_ok = (32'(bus.req_sel) < NUM_CH);
   assign cur_oh = NUM_CH'(onehot(32'(cur_sel_q), NUM_CH));

   al_clksw_cnt #(.WIDTH(CNT_W)) u_hold_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (hold_load),
      .load_val (hold_val),
      .dec      (hold_dec),
      .tc       (hold_tc)
   );

   al_clksw_cnt #(.WIDTH(CNT_W)) u_tout_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (tout_load),
      .load_val (TOUT_LD),
      .dec      (tout_dec),
      .tc       (tout_tc)
   );

   // Next-state, request decode and counter control
   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      prev_d    = prev_q;
      cur_sel_d = cur_sel_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      hold_load = 1'b0;
      hold_val  = HOLD_LD;
      hold_dec  = 1'b0;
      tout_load = 1'b0;
      tout_dec  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               if (!req_ok) begin
                  err_d = 1'b1;
               end else if (bus.req_sel == cur_sel_q) begin
                  done_d = 1'b1;
               end else begin
                  target_d  = bus.req_sel;
                  prev_d    = cur_sel_q;
                  hold_load = 1'b1;
                  hold_val  = DRAIN_LD;
                  state_d   = StDrain;
               end
            end
         end
         StDrain: begin
            hold_dec = 1'b1;
            if (hold_tc) begin
               cur_sel_d = target_q;
               state_d   = StSwitch;
            end
         end
         StSwitch: begin
            hold_load = 1'b1;
            tout_load = 1'b1;
            state_d   = StArm;
         end
         StArm: begin
            hold_dec = 1'b1;
            tout_dec = 1'b1;
            // A live target seen on the expiry cycle still counts as success
            if (hold_tc && bus.ch_alive[target_q]) begin
               state_d = StEnable;
            end else if (tout_tc) begin
               cur_sel_d = prev_q;
               hold_load = 1'b1;
               state_d   = StRevert;
            end
         end
         StEnable: begin
            state_d = StIdle;
         end
         StRevert: begin
            hold_dec = 1'b1;
            if (hold_tc) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         target_q  <= SEL_W'(INIT_SEL);
         prev_q    <= SEL_W'(INIT_SEL);
         cur_sel_q <= SEL_W'(INIT_SEL);
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         prev_q    <= prev_d;
         cur_sel_q <= cur_sel_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Clock enable follows the selected channel only when it is known to be stable
   always_comb begin
      ce_c = '0;
      unique case (state_q)
         StIdle, StEnable: ce_c = cur_oh;
         StRevert:         ce_c = hold_tc ? cur_oh : '0;
         default:          ce_c = '0;
      endcase
   end

   assign bus.ce        = ce_c;
   assign bus.sel       = cur_oh;
   assign bus.cur_sel   = cur_sel_q;
   assign bus.req_ready = (state_q == StIdle);
   assign bus.done      = done_q | (state_q == StEnable);
   assign bus.err       = err_q | ((state_q == StRevert) && hold_tc);
endmodule

// File: tb/tb_al_logic_clksw_ctrl.sv
// Scoreboard bench for the clock-switch sequencer: 4-channel main instance, 3-channel side instance.
module tb_al_logic_clksw_ctrl;
   localparam int unsigned HOLD = 4;
   localparam int unsigned TOUT = 16;
   localparam int NOM = 2 * HOLD + 3;

   typedef struct {
      bit         is_err;
      int         at;
      logic [1:0] cur;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t q[$];
   exp_t q3[$];
   logic [3:0] prev_sel;
   logic [1:0] m_cur;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   al_logic_clksw_ctrl_if #(.NUM_CH(4), .SEL_W(2)) bus ();
   al_logic_clksw_ctrl_if #(.NUM_CH(3), .SEL_W(2)) bus3 ();

   al_logic_clksw_ctrl #(
      .NUM_CH(4), .SEL_W(2), .INIT_SEL(2), .HOLD_CYC(HOLD), .TIMEOUT_CYC(TOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   al_logic_clksw_ctrl #(
      .NUM_CH(3), .SEL_W(2), .INIT_SEL(0), .HOLD_CYC(2), .TIMEOUT_CYC(8)
   ) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] s, input bit is_err, input int lat, input logic [1:0] c);
      exp_t e;
      e.is_err = is_err;
      e.at     = cyc + lat;
      e.cur    = c;
      q.push_back(e);
      bus.req_valid = 1'b1;
      bus.req_sel   = s;
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic issue3(input logic [1:0] s, input bit is_err, input int lat, input logic [1:0] c);
      exp_t e;
      e.is_err = is_err;
      e.at     = cyc + lat;
      e.cur    = c;
      q3.push_back(e);
      bus3.req_valid = 1'b1;
      bus3.req_sel   = s;
      tick();
      bus3.req_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && (q.size() != 0 || q3.size() != 0); i++) tick();
      check("response_timeout", q.size() + q3.size(), 0);
      q.delete();
      q3.delete();
   endtask

   // Monitor for the main instance: every done/err must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && (bus.done || bus.err)) begin
         if (q.size() == 0) begin
            check("unexpected_resp", {bus.done, bus.err}, 2'b00);
         end else begin
            exp_t e;
            logic [3:0] oh;
            e  = q.pop_front();
            oh = 4'b0001 << e.cur;
            check("resp_err", bus.err, e.is_err);
            check("resp_done", bus.done, !e.is_err);
            check("resp_cycle", cyc, e.at);
            check("resp_cur_sel", bus.cur_sel, e.cur);
            check("resp_sel", bus.sel, oh);
            check("resp_ce", bus.ce, oh);
         end
      end
   end

   // Monitor for the 3-channel instance
   always @(negedge clk) begin
      if (!rst && (bus3.done || bus3.err)) begin
         if (q3.size() == 0) begin
            check("unexpected_resp3", {bus3.done, bus3.err}, 2'b00);
         end else begin
            exp_t e;
            logic [2:0] oh;
            e  = q3.pop_front();
            oh = 3'b001 << e.cur;
            check("resp3_err", bus3.err, e.is_err);
            check("resp3_cycle", cyc, e.at);
            check("resp3_cur_sel", bus3.cur_sel, e.cur);
            check("resp3_sel", bus3.sel, oh);
            check("resp3_ce", bus3.ce, oh);
         end
      end
   end

   // Per-cycle invariants on the main instance
   always @(negedge clk) begin
      if (!rst) begin
         n_checks++;
         if ($countones(bus.ce) > 1 || $countones(bus.sel) != 1 || (bus.ce & ~bus.sel) != 4'b0
             || (bus.done && bus.err) || (bus.sel != prev_sel && bus.ce != 4'b0)) begin
            n_fail++;
            $display("FAIL invariant: ce=%b sel=%b prev_sel=%b done=%b err=%b (cycle %0d)",
                     bus.ce, bus.sel, prev_sel, bus.done, bus.err, cyc);
         end
      end
      prev_sel = bus.sel;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int sw;
      logic [1:0] s;
      rst = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_sel   = 2'd0;
      bus.ch_alive  = 4'hF;
      bus3.req_valid = 1'b0;
      bus3.req_sel   = 2'd0;
      bus3.ch_alive  = 3'b111;
      repeat (3) tick();
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_ce", bus.ce, 4'b0100);
      check("rst_sel", bus.sel, 4'b0100);
      check("rst_cur_sel", bus.cur_sel, 2);
      check("rst_ready", bus.req_ready, 1'b1);
      check("rst_done_err", {bus.done, bus.err}, 2'b00);
      check("rst3_sel", bus3.sel, 3'b001);

      // Nominal 2->3 with cycle-by-cycle trace
      t0 = cyc;
      q.push_back('{is_err: 1'b0, at: t0 + NOM, cur: 2'd3});
      bus.req_valid = 1'b1;
      bus.req_sel   = 2'd3;
      tick();
      bus.req_valid = 1'b0;
      for (int n = 1; n <= NOM; n++) begin
         @(negedge clk);
         check("nom_ready_low", bus.req_ready, 1'b0);
         if (n == 1) check("nom_ce_off", bus.ce, 4'b0000);
         if (n == HOLD) check("nom_sel_old", bus.sel, 4'b0100);
         if (n == HOLD + 1) check("nom_sel_new", bus.sel, 4'b1000);
         tick();
      end
      check("nom_ready_back", bus.req_ready, 1'b1);
      drain(20);

      // Same channel, then a plain switch back to 0
      issue(2'd3, 1'b0, 1, 2'd3);
      drain(10);
      issue(2'd0, 1'b0, NOM, 2'd0);
      drain(30);

      // Dead target: DRAIN+SWITCH, full timeout in ARM, HOLD quiet cycles then err
      bus.ch_alive = 4'b1101;
      issue(2'd1, 1'b1, (HOLD + 1) + TOUT + (HOLD + 1), 2'd0);
      drain(60);
      bus.ch_alive = 4'hF;

      // Late alive: target comes up 10 cycles after ARM entry (ARM entry is cycle HOLD+2)
      bus.ch_alive = 4'b0111;
      issue(2'd3, 1'b0, HOLD + 2 + 10 + 1, 2'd3);
      repeat (HOLD + 2 + 10 - 1) tick();
      bus.ch_alive = 4'hF;
      drain(30);

      // 3-channel instance: out-of-range index, same channel, real switch, out-of-range again
      issue3(2'd3, 1'b1, 1, 2'd0);
      drain(10);
      issue3(2'd0, 1'b0, 1, 2'd0);
      drain(10);
      issue3(2'd1, 1'b0, 2 * 2 + 3, 2'd1);
      drain(20);
      issue3(2'd3, 1'b1, 1, 2'd1);
      drain(10);

      // Back-to-back: req_valid held high, busy-cycle requests must be ignored
      m_cur = 2'd3;
      sw = 0;
      bus.req_valid = 1'b1;
      while (sw < 20) begin
         s = 2'($urandom_range(0, 3));
         bus.req_sel = s;
         q.push_back('{is_err: 1'b0, at: cyc + ((s == m_cur) ? 1 : NOM), cur: s});
         @(negedge clk);
         check("b2b_ready_idle", bus.req_ready, 1'b1);
         tick();
         if (s != m_cur) begin
            sw++;
            for (int n = 1; n <= NOM; n++) begin
               bus.req_sel = 2'($urandom_range(0, 3));
               @(negedge clk);
               check("b2b_ready_busy", bus.req_ready, 1'b0);
               tick();
            end
         end
         m_cur = s;
      end
      bus.req_valid = 1'b0;
      drain(20);

      // Reset in the middle of ARM: no response may appear, outputs return to INIT_SEL
      bus.req_valid = 1'b1;
      bus.req_sel   = m_cur + 2'd1;
      tick();
      bus.req_valid = 1'b0;
      repeat (HOLD + 3) tick();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("midrst_ce", bus.ce, 4'b0100);
      check("midrst_sel", bus.sel, 4'b0100);
      check("midrst_cur_sel", bus.cur_sel, 2);
      check("midrst_ready", bus.req_ready, 1'b1);
      tick();
      issue(2'd2, 1'b0, 1, 2'd2);
      drain(10);
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
